// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and widths for the keypad scan writer
package keypad_pkg;
  localparam int KEY_W = 4;
  localparam int SEL_W = 3;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} result_t;
endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: column scan, row synchronizer and per-frame key classification
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic             frame_end,
  output result_t          frame_result,
  output logic [KEY_W-1:0] frame_key
);
  logic [3:0] rs1, rs2, lows;
  logic [15:0] ph;
  logic [1:0] col, hits, ridx;
  logic [2:0] n, tot;
  logic [KEY_W-1:0] key_acc;
  logic sample;
  assign sample = ph == 16'(SCAN_DIV - 1);
  assign frame_end = sample && col == 2'd3;
  assign col_n = ~(4'b0001 << col);
  always_comb begin
    lows = ~rs2;
    n = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
    ridx = lows[0] ? 2'd0 : lows[1] ? 2'd1 : lows[2] ? 2'd2 : 2'd3;
    tot = 3'(hits) + n;
    frame_result = tot == 3'd0 ? NONE : tot == 3'd1 ? SINGLE : MULTI;
    frame_key = hits != 2'd0 ? key_acc : {ridx, col};
  end
  // hits saturates at 2: anything beyond one low row is already MULTI
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rs1 <= '1;
      rs2 <= '1;
      ph <= '0;
      col <= '0;
      hits <= '0;
      key_acc <= '0;
    end else begin
      rs1 <= row_n;
      rs2 <= rs1;
      if (sample) begin
        ph <= '0;
        col <= col + 2'd1;
        hits <= frame_end ? 2'd0 : tot > 3'd1 ? 2'd2 : tot[1:0];
        key_acc <= hits == 2'd0 ? {ridx, col} : key_acc;
      end else
        ph <= ph + 16'd1;
    end
endmodule

// File: rtl/keypad_scan_writer.sv
// keypad_scan_writer: debounced keypad to display-latch writer
// KEYPAD_AUTOREPEAT_EN adds periodic repeat strobes while a key stays held
module keypad_scan_writer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic [KEY_W-1:0] wr_data,
  output logic [SEL_W-1:0] wr_sel,
  output logic             wr_en,
  output logic             key_held
);
  state_t state, state_d;
  result_t frame_result;
  logic frame_end, wr_en_d;
  logic [KEY_W-1:0] frame_key, cand, cand_d, wr_data_d;
  logic [3:0] cnt, cnt_d;
  logic single;
  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .frame_end(frame_end), .frame_result(frame_result), .frame_key(frame_key)
  );
  assign single = frame_result == SINGLE;
  assign key_held = state == HELD || state == RELEASE_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0] rpt, rpt_d;
`else
  logic unused_repeat;
  assign unused_repeat = REPEAT_FRAMES > 0;
`endif
  always_comb begin
    state_d = state;
    cand_d = cand;
    cnt_d = cnt;
    wr_data_d = wr_data;
    wr_en_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d = rpt;
`endif
    if (frame_end)
      case (state)
        IDLE:
          if (single) begin
            cand_d = frame_key;
            cnt_d = 4'd1;
            state_d = PRESS_DB;
          end
        PRESS_DB:
          if (single && frame_key == cand) begin
            cnt_d = cnt + 4'd1;
            if (cnt_d == 4'(DEBOUNCE_FRAMES)) begin
              state_d = HELD;
              wr_data_d = cand;
              wr_en_d = 1'b1;
            end
          end else begin
            cnt_d = 4'd0;
            state_d = IDLE;
          end
        HELD: begin
          if (frame_result == NONE) begin
            cnt_d = 4'd1;
            state_d = RELEASE_DB;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_d = single && frame_key == wr_data ? rpt + 8'd1 : 8'd0;
          if (rpt_d == 8'(REPEAT_FRAMES)) begin
            rpt_d = 8'd0;
            wr_en_d = 1'b1;
          end
`endif
        end
        RELEASE_DB:
          if (frame_result == NONE) begin
            cnt_d = cnt + 4'd1;
            if (cnt_d == 4'(DEBOUNCE_FRAMES)) state_d = IDLE;
          end else
            state_d = HELD;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      wr_data <= '0;
      wr_en <= 1'b0;
      wr_sel <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt <= '0;
`endif
    end else begin
      state <= state_d;
      cand <= cand_d;
      cnt <= cnt_d;
      wr_data <= wr_data_d;
      wr_en <= wr_en_d;
      if (wr_en) wr_sel <= wr_sel + 3'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt <= rpt_d;
`endif
    end
endmodule

// File: tb/tb_keypad_scan_writer.sv
// tb_keypad_scan_writer: directed checks of scan, debounce, addressing and reset
module tb_keypad_scan_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] row_n, col_n, wr_data;
  logic [2:0] wr_sel;
  logic wr_en, key_held;
  logic [15:0] keys = '0;
  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int s0;
  logic [2:0] sels[$];
  keypad_scan_writer #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_en(wr_en), .key_held(key_held)
  );
  always #5 clk = ~clk;
  always_comb
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[4*r +: 4] & ~col_n);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic frame(input logic [15:0] m);
    keys = m;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        strobes++;
        sels.push_back(wr_sel);
      end
    end
  endtask
  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) frame(m);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    keys = '0;
    repeat (2) @(negedge clk);
    strobes = 0;
    sels.delete();
    rst = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_col", 32'(col_n), 32'hE);
    check("rst_data", 32'(wr_data), 32'h0);
    check("rst_sel", 32'(wr_sel), 32'h0);
    check("rst_en", 32'(wr_en), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    do_reset();
    // clean press of key 6 (row 1, col 2)
    frames(16'h0040, 2);
    check("clean_pre_strobes", 32'(strobes), 32'd0);
    check("clean_pre_held", 32'(key_held), 32'h0);
    frame(16'h0040);
    check("clean_en", 32'(wr_en), 32'h1);
    check("clean_data", 32'(wr_data), 32'h6);
    check("clean_sel_at_en", 32'(wr_sel), 32'h0);
    check("clean_held", 32'(key_held), 32'h1);
    frames(16'h0040, 2);
    check("clean_sel_after", 32'(wr_sel), 32'h1);
    check("clean_strobes", 32'(strobes), 32'd1);
    frames(16'h0000, 2);
    check("release_still_held", 32'(key_held), 32'h1);
    frame(16'h0000);
    check("release_held", 32'(key_held), 32'h0);
    check("release_keeps_data", 32'(wr_data), 32'h6);
    // bounce on key A: frame 3 drops out
    do_reset();
    frames(16'h0400, 2);
    frame(16'h0000);
    frames(16'h0400, 2);
    check("bounce_no_strobe", 32'(strobes), 32'd0);
    frame(16'h0400);
    check("bounce_en", 32'(wr_en), 32'h1);
    check("bounce_data", 32'(wr_data), 32'hA);
    frame(16'h0400);
    check("bounce_strobes", 32'(strobes), 32'd1);
    // keys 0 and 5 together, then 5 released
    do_reset();
    frames(16'h0021, 6);
    check("multi_strobes", 32'(strobes), 32'd0);
    check("multi_held", 32'(key_held), 32'h0);
    frames(16'h0001, 2);
    check("multi_wait", 32'(strobes), 32'd0);
    frame(16'h0001);
    check("multi_en", 32'(wr_en), 32'h1);
    check("multi_data", 32'(wr_data), 32'h0);
    check("multi_held_after", 32'(key_held), 32'h1);
    frames(16'h0000, 3);
    // nine presses of key 3 wrap the address
    do_reset();
    for (int i = 0; i < 9; i++) begin
      frames(16'h0008, 3);
      frames(16'h0000, 3);
    end
    check("wrap_strobes", 32'(strobes), 32'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("wrap_sel%0d", i), 32'(i < sels.size() ? sels[i] : 3'bx), 32'(i % 8));
    check("wrap_sel_final", 32'(wr_sel), 32'h1);
    check("wrap_data", 32'(wr_data), 32'h3);
    // reset lands mid-debounce with key 6 still down
    frames(16'h0040, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_col", 32'(col_n), 32'hE);
    check("midrst_data", 32'(wr_data), 32'h0);
    check("midrst_sel", 32'(wr_sel), 32'h0);
    check("midrst_en", 32'(wr_en), 32'h0);
    check("midrst_held", 32'(key_held), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    s0 = strobes;
    frames(16'h0040, 2);
    check("midrst_no_early", 32'(strobes - s0), 32'd0);
    frame(16'h0040);
    check("midrst_en", 32'(wr_en), 32'h1);
    check("midrst_data_acc", 32'(wr_data), 32'h6);
    check("midrst_sel_acc", 32'(wr_sel), 32'h0);
    // long hold of key F: repeats only with the optional feature
    do_reset();
    for (int f = 1; f <= 13; f++) begin
      frame(16'h8000);
`ifdef KEYPAD_AUTOREPEAT_EN
      check($sformatf("hold_en_f%0d", f), 32'(wr_en), 32'(f == 3 || f == 7 || f == 11));
`else
      check($sformatf("hold_en_f%0d", f), 32'(wr_en), 32'(f == 3));
`endif
    end
    check("hold_data", 32'(wr_data), 32'hF);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_sel", 32'(wr_sel), 32'h3);
`else
    check("hold_sel", 32'(wr_sel), 32'h1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
